vga_timing_gen: RTL

Parametrised VGA timing generator that replaces the fixed 800x600 sync counter and the hand-written sync bypass registers used around it. Produces horizontal/vertical counters, a pixel request with active-area coordinates for the pixel/ROM pipeline, and hsync/vsync/de outputs delayed by a configurable number of stages so they line up with the pipeline's RGB result. A clock-enable input lets the block run from a faster system clock than the pixel rate.

---
 rtl/vga_timing_pkg.sv | 39 +++
 rtl/vga_delay_line.sv | 45 ++++
 rtl/vga_timing_gen.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Timing constants for 800x600@60 (40 MHz pixel clock), sync polarities and
// small shared types/helpers for the VGA timing generator.
package vga_timing_pkg;

  localparam int unsigned VGA_H_SYNC = 128;
  localparam int unsigned VGA_H_BP   = 88;
  localparam int unsigned VGA_H_ACT  = 800;
  localparam int unsigned VGA_H_FP   = 40;
  localparam int unsigned VGA_V_SYNC = 4;
  localparam int unsigned VGA_V_BP   = 23;
  localparam int unsigned VGA_V_ACT  = 600;
  localparam int unsigned VGA_V_FP   = 1;

  localparam bit VGA_HS_POL = 1'b1;
  localparam bit VGA_VS_POL = 1'b1;

  localparam int unsigned VGA_H_TOTAL = VGA_H_SYNC + VGA_H_BP + VGA_H_ACT + VGA_H_FP;
  localparam int unsigned VGA_V_TOTAL = VGA_V_SYNC + VGA_V_BP + VGA_V_ACT + VGA_V_FP;

  localparam int unsigned VGA_PIPE_DELAY = 2;
  localparam int unsigned VGA_CW         = 11;

  // Number of colour bars in the built-in pattern and width of the bar index
  localparam int unsigned VGA_NUM_BARS = 8;
  localparam int unsigned VGA_BAR_W    = 3;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_t;

  // True when lo <= v < lo + len
  function automatic logic in_range(input int unsigned v, input int unsigned lo,
                                    input int unsigned len);
    return (v >= lo) && (v < lo + len);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enabled shift register of configurable width and depth (DEPTH >= 1) with a
// per-bit reset value. o_tap is the value that o_q will take on the next
// enabled edge, so a register downstream can update in step with o_q.
module vga_delay_line #(
  parameter int unsigned         WIDTH   = 3,
  parameter int unsigned         DEPTH   = 1,
  parameter logic [WIDTH-1:0]    RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_tap
);

  if (DEPTH < 1) begin : g_bad_depth
    $error("vga_delay_line: DEPTH must be at least 1");
  end

  logic [WIDTH-1:0] r_sr [DEPTH];

  // Shift one stage per enabled cycle; reset fills every stage with RST_VAL
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_sr[i] <= RST_VAL;
      end
    end else if (i_en) begin
      r_sr[0] <= i_d;
      for (int i = 1; i < int'(DEPTH); i++) begin
        r_sr[i] <= r_sr[i-1];
      end
    end
  end

  assign o_q = r_sr[DEPTH-1];

  if (DEPTH == 1) begin : g_tap_in
    assign o_tap = i_d;
  end else begin : g_tap_sr
    assign o_tap = r_sr[DEPTH-2];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: h/v counters, stage-0 pixel request with
// active-area coordinates, and hsync/vsync/de/rgb delayed by PIPE_DELAY enabled
// cycles. Optional colour-bar pattern guarded by VGA_TIMING_TEST_PATTERN_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_SYNC     = VGA_H_SYNC,
  parameter int unsigned H_BP       = VGA_H_BP,
  parameter int unsigned H_ACT      = VGA_H_ACT,
  parameter int unsigned H_FP       = VGA_H_FP,
  parameter int unsigned V_SYNC     = VGA_V_SYNC,
  parameter int unsigned V_BP       = VGA_V_BP,
  parameter int unsigned V_ACT      = VGA_V_ACT,
  parameter int unsigned V_FP       = VGA_V_FP,
  parameter bit          HS_POL     = VGA_HS_POL,
  parameter bit          VS_POL     = VGA_VS_POL,
  parameter int unsigned PIPE_DELAY = VGA_PIPE_DELAY,
  parameter int unsigned CW         = VGA_CW
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic [2:0]    i_rgb_in,
  input  logic          i_pattern_en,
  output logic          o_req,
  output logic [CW-1:0] o_x,
  output logic [CW-1:0] o_y,
  output logic          o_frame_start,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_de,
  output logic [2:0]    o_rgb
);

  localparam int unsigned H_TOTAL     = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int unsigned V_TOTAL     = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int unsigned H_ACT_START = H_SYNC + H_BP;
  localparam int unsigned V_ACT_START = V_SYNC + V_BP;

  if ((64'(H_TOTAL) >= (64'd1 << CW)) || (64'(V_TOTAL) >= (64'd1 << CW))) begin : g_bad_cw
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must be below 2**CW");
  end
  if (PIPE_DELAY > 15) begin : g_bad_delay
    $error("vga_timing_gen: PIPE_DELAY must be 0..15");
  end

  // Delay-line word: {hs, vs, de} plus the bar index when the pattern is built
`ifdef VGA_TIMING_TEST_PATTERN_EN
  localparam int unsigned DL_W = 3 + VGA_BAR_W;
  localparam logic [DL_W-1:0] DL_RST = {!HS_POL, !VS_POL, 1'b0, {VGA_BAR_W{1'b0}}};
`else
  localparam int unsigned DL_W = 3;
  localparam logic [DL_W-1:0] DL_RST = {!HS_POL, !VS_POL, 1'b0};
`endif
  localparam int unsigned DE_BIT = DL_W - 3;

  logic [CW-1:0]   r_hcnt, r_vcnt, w_hcnt_d, w_vcnt_d;
  logic            w_h_last, w_v_last;
  sync_t           w_s0;
  logic [CW-1:0]   w_x_d, w_y_d;
  logic            w_fs_d;
  logic            r_req, r_fs;
  logic [CW-1:0]   r_x, r_y;
  logic [DL_W-1:0] w_dl_d, w_dl_q, w_dl_tap;
  logic [2:0]      w_rgb_d, r_rgb;

  // Counter next-state: hcnt wraps at H_TOTAL-1 and carries into vcnt
  always_comb begin
    w_h_last = (r_hcnt == CW'(H_TOTAL - 1));
    w_v_last = (r_vcnt == CW'(V_TOTAL - 1));
    w_hcnt_d = w_h_last ? '0 : r_hcnt + CW'(1);
    w_vcnt_d = r_vcnt;
    if (w_h_last) begin
      w_vcnt_d = w_v_last ? '0 : r_vcnt + CW'(1);
    end
  end

  // Counter registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (i_en) begin
      r_hcnt <= w_hcnt_d;
      r_vcnt <= w_vcnt_d;
    end
  end

  // Stage-0 decode of the current counter position
  always_comb begin
    w_s0.hs = (r_hcnt < CW'(H_SYNC)) ? HS_POL : !HS_POL;
    w_s0.vs = (r_vcnt < CW'(V_SYNC)) ? VS_POL : !VS_POL;
    w_s0.de = in_range(32'(r_hcnt), H_ACT_START, H_ACT) &&
              in_range(32'(r_vcnt), V_ACT_START, V_ACT);
    w_x_d   = w_s0.de ? r_hcnt - CW'(H_ACT_START) : '0;
    w_y_d   = w_s0.de ? r_vcnt - CW'(V_ACT_START) : '0;
    w_fs_d  = (r_hcnt == '0) && (r_vcnt == '0);
  end

  // Stage-0 request/coordinate registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_req <= 1'b0;
      r_x   <= '0;
      r_y   <= '0;
      r_fs  <= 1'b0;
    end else if (i_en) begin
      r_req <= w_s0.de;
      r_x   <= w_x_d;
      r_y   <= w_y_d;
      r_fs  <= w_fs_d;
    end
  end

  // The first delay-line stage is stage 0 itself, hence DEPTH = PIPE_DELAY + 1
`ifdef VGA_TIMING_TEST_PATTERN_EN
  logic [VGA_BAR_W-1:0] w_bar_d;
  assign w_bar_d = VGA_BAR_W'((32'(w_x_d) * VGA_NUM_BARS) / H_ACT);
  assign w_dl_d  = {w_s0, w_bar_d};
`else
  assign w_dl_d  = w_s0;
`endif

  vga_delay_line #(
    .WIDTH   (DL_W),
    .DEPTH   (PIPE_DELAY + 1),
    .RST_VAL (DL_RST)
  ) u_sync_dly (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (i_en),
    .i_d   (w_dl_d),
    .o_q   (w_dl_q),
    .o_tap (w_dl_tap)
  );

  // Colour select for the edge that loads de; rgb_in is sampled on that edge
  always_comb begin
    w_rgb_d = 3'b000;
    if (w_dl_tap[DE_BIT]) begin
      w_rgb_d = i_rgb_in;
`ifdef VGA_TIMING_TEST_PATTERN_EN
      if (i_pattern_en) begin
        w_rgb_d = w_dl_tap[VGA_BAR_W-1:0];
      end
`endif
    end
  end

  // Output colour register, updated together with the delay line
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rgb <= 3'b000;
    end else if (i_en) begin
      r_rgb <= w_rgb_d;
    end
  end

`ifdef VGA_TIMING_TEST_PATTERN_EN
  // Delayed bar index is consumed through the tap, not the final stage
  logic w_unused_bar;
  assign w_unused_bar = ^w_dl_q[VGA_BAR_W-1:0];
`else
  logic w_unused_pattern_en;
  assign w_unused_pattern_en = i_pattern_en;
`endif

  assign o_req         = r_req;
  assign o_x           = r_x;
  assign o_y           = r_y;
  assign o_frame_start = r_fs;
  assign o_hsync       = w_dl_q[DL_W-1];
  assign o_vsync       = w_dl_q[DL_W-2];
  assign o_de          = w_dl_q[DE_BIT];
  assign o_rgb         = r_rgb;

endmodule
